dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
Posted-store buffer between the CPU MEM stage and the d-side port of cache_system (d_mem_*). Stores retire to the CPU in one cycle and drain to the d-cache in the background. Loads forward from the buffer when the youngest matching entry fully covers the word, and bypass older non-conflicting stores. Loads that conflict with a partial-byte store wait until the buffer drains that entry.

Parameters:
DEPTH, 4, number of store entries (power of 2, ≥2)
PTR_W, $clog2(DEPTH), width of the head and tail pointers

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous and active-high
cpu_read  in  1  load request, held until cpu_resp
cpu_write  in  1  store request, held until cpu_resp
cpu_addr  in  32  byte address; bits [1:0] are ignored for matching
cpu_wdata  in  32  store data
cpu_byte_enable  in  4  store byte mask
cpu_rdata  out  32  load data, valid when cpu_resp is high
cpu_resp  out  1  one-cycle completion pulse
d_mem_read  out  1  read request to cache_system
d_mem_write  out  1  write request to cache_system
d_mem_addr  out  32  word-aligned address
d_mem_wdata  out  32  write data
d_mem_byte_enable  out  4  write mask
d_mem_rdata  in  32  read data
d_mem_resp  in  1  cache completion
sb_empty  out  1  count==0 and state==IDLE; used by fences

Behaviour:
- Reset (synchronous, active-high):
  - count, head and tail are 0; all entries are invalid; state is IDLE.
  - d_mem_read, d_mem_write, cpu_resp and cpu_rdata are 0; sb_empty is 1.
  - Reset during DRAIN or LOAD drops the d_mem request in the next cycle and discards buffer contents.
- Entry format: {addr[31:2], data[31:0], be[3:0]}. The FIFO is circular; pointers wrap modulo DEPTH.
- Store:
  - Accepted in cycle T when count<DEPTH, or when count==DEPTH and a pop occurs in T (d_mem_resp in DRAIN).
  - On accept: write the tail entry and assert cpu_resp combinationally in T.
  - If neither condition holds, cpu_resp stays 0 and the CPU holds the request.
- cpu_read and cpu_write both high: illegal (bench asserts on it). The write takes precedence.
- Load match: compare cpu_addr[31:2] against all valid entries; the youngest match wins.
  - Youngest match with be==4'hF: forward its data with cpu_resp in the same cycle, no cache access. The load may complete in any state.
  - Youngest match with partial be: conflict; the load stalls until no matching entry remains.
  - No match: the load is eligible for the cache.
- FSM, states IDLE, LOAD, DRAIN:
  - IDLE, eligible load pending: latch the word address, go to LOAD. Loads take priority over draining.
  - IDLE, otherwise if count>0 (including while a conflicted load stalls): latch the head entry, go to DRAIN.
  - LOAD: d_mem_read=1 with the latched address. On d_mem_resp: cpu_resp=1, cpu_rdata=d_mem_rdata, return to IDLE.
  - DRAIN: d_mem_write=1 with the latched head entry. On d_mem_resp: pop (head++, count--), return to IDLE.
- d_mem outputs are registered and stable from the assertion of a request until d_mem_resp. A request is never aborted except by rst.
- Minimum latencies:
  - Forwarded load or buffered store: 0 extra cycles.
  - Cache load: 1 cycle to enter LOAD, plus the cache latency.
  - Back-to-back drains: one IDLE cycle between writes.
- count is PTR_W+1 bits. A simultaneous push and pop leaves count unchanged.
- Stores are written to the cache strictly in FIFO order. A load never observes data older than a buffered store to the same word.

Decomposition:
- Package sb_pkg:
  - sb_entry_t struct {word_addr[29:0], data, be}
  - sb_state_e enum {IDLE, LOAD, DRAIN}
  - FULL_BE constant 4'hF
- Sub-module sb_fifo: circular storage, push/pop, count, full/empty, and youngest-match search returning {hit, full_cover, data}.
- dmem_store_buffer holds the FSM and the output muxing.

Test Plan:
1. Store 0x1000 = 0xDEADBEEF, be=F, into an empty buffer → cpu_resp in the same cycle. The buffer then issues d_mem_write addr 0x1000, be F, wdata 0xDEADBEEF, held until d_mem_resp. After resp, sb_empty=1.
2. Store 0x2000 = 0x11223344 (be F), then load 0x2000 before the drain completes → cpu_resp in the same cycle, cpu_rdata=0x11223344, no d_mem_read issued.
3. Store 0x3000 with be=4'b0011, then load 0x3004 → the load goes to LOAD ahead of the drain (d_mem_read addr 0x3004). A following load of 0x3000 stalls until the store drains, then reads the cache.
4. Fill with 4 stores while d_mem_resp is held low → the fifth store gets no cpu_resp. It is accepted in the cycle the head pops (count stays 4). All five writes reach the cache in order, with head/tail wrapping.
5. Two stores to 0x4000 (0xAAAAAAAA, then 0xBBBBBBBB, both be F), then load 0x4000 → forwards 0xBBBBBBBB.
6. Assert rst mid-DRAIN with 2 entries buffered → the next cycle has d_mem_write=0, sb_empty=1, and no subsequent writes.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types for the data-side posted-store buffer.
package sb_pkg;

    // A byte mask that covers the whole 32-bit word.
    localparam logic [3:0] FULL_BE = 4'hF;

    // One buffered store: word address, data and byte mask.
    typedef struct packed {
        logic [29:0] word_addr;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

    // Controller states: idle, cache load in flight, head store draining.
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } sb_state_e;

endpackage

// File: rtl/sb_fifo.sv
// Circular store FIFO with a youngest-match lookup used for load forwarding.
module sb_fifo
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [29:0] push_addr,
    input  logic [31:0] push_data,
    input  logic [3:0]  push_be,
    input  logic        pop,
    input  logic [29:0] lookup_addr,
    output logic [29:0] head_addr,
    output logic [31:0] head_data,
    output logic [3:0]  head_be,
    output logic        full,
    output logic        empty,
    output logic        hit,
    output logic        full_cover,
    output logic [31:0] hit_data
);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(DEPTH);

    sb_entry_t            entries [DEPTH];
    logic [DEPTH-1:0]     valid;
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [PTR_W:0]       count;

    assign full      = (count == CNT_DEPTH);
    assign empty     = (count == '0);
    assign head_addr = entries[head].word_addr;
    assign head_data = entries[head].data;
    assign head_be   = entries[head].be;

    // Pointer, valid and occupancy bookkeeping; a push into the slot being popped keeps it valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_ONE;
            end
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry payload storage; contents are meaningless while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= '{word_addr: push_addr, data: push_data, be: push_be};
        end
    end

    // Walk from oldest to youngest so the last matching entry seen is the youngest one.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        hit        = 1'b0;
        full_cover = 1'b0;
        hit_data   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && (entries[idx].word_addr == lookup_addr)) begin
                hit        = 1'b1;
                full_cover = (entries[idx].be == FULL_BE);
                hit_data   = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-store buffer between the CPU MEM stage and the d-side cache port.
module dmem_store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byte_enable,
    output logic [31:0] cpu_rdata,
    output logic        cpu_resp,
    output logic        d_mem_read,
    output logic        d_mem_write,
    output logic [31:0] d_mem_addr,
    output logic [31:0] d_mem_wdata,
    output logic [3:0]  d_mem_byte_enable,
    input  logic [31:0] d_mem_rdata,
    input  logic        d_mem_resp,
    output logic        sb_empty
);

    sb_state_e   state;
    logic        fifo_full;
    logic        fifo_empty;
    logic        hit;
    logic        full_cover;
    logic [31:0] hit_data;
    logic [29:0] head_addr;
    logic [31:0] head_data;
    logic [3:0]  head_be;
    logic        pop;
    logic        store_accept;
    logic        load_fwd;
    logic        load_done;
    logic        load_eligible;
    logic        unused_addr_bits;

    // Byte offset bits never take part in matching or cache addressing.
    assign unused_addr_bits = ^cpu_addr[1:0];

    // A full buffer can still take a store in the same cycle the head drains.
    assign pop           = (state == DRAIN) && d_mem_resp;
    assign store_accept  = cpu_write && (!fifo_full || pop);
    assign load_fwd      = cpu_read && !cpu_write && hit && full_cover;
    assign load_done     = (state == LOAD) && d_mem_resp;
    assign load_eligible = cpu_read && !cpu_write && !hit;

    assign cpu_resp = !rst && (store_accept || load_fwd || load_done);
    assign sb_empty = fifo_empty && (state == IDLE);

    sb_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (store_accept),
        .push_addr   (cpu_addr[31:2]),
        .push_data   (cpu_wdata),
        .push_be     (cpu_byte_enable),
        .pop         (pop),
        .lookup_addr (cpu_addr[31:2]),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .head_be     (head_be),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .hit         (hit),
        .full_cover  (full_cover),
        .hit_data    (hit_data)
    );

    // Load data comes from the cache on completion, otherwise from a fully covering buffered store.
    always_comb begin
        cpu_rdata = '0;
        if (!rst) begin
            if (load_done) begin
                cpu_rdata = d_mem_rdata;
            end else if (load_fwd) begin
                cpu_rdata = hit_data;
            end
        end
    end

    // Cache-side controller; loads win over draining and requests hold until the cache responds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            d_mem_read        <= 1'b0;
            d_mem_write       <= 1'b0;
            d_mem_addr        <= '0;
            d_mem_wdata       <= '0;
            d_mem_byte_enable <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_eligible) begin
                        state      <= LOAD;
                        d_mem_read <= 1'b1;
                        d_mem_addr <= {cpu_addr[31:2], 2'b00};
                    end else if (!fifo_empty) begin
                        state             <= DRAIN;
                        d_mem_write       <= 1'b1;
                        d_mem_addr        <= {head_addr, 2'b00};
                        d_mem_wdata       <= head_data;
                        d_mem_byte_enable <= head_be;
                    end
                end
                LOAD: begin
                    if (d_mem_resp) begin
                        state      <= IDLE;
                        d_mem_read <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (d_mem_resp) begin
                        state       <= IDLE;
                        d_mem_write <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    d_mem_read  <= 1'b0;
                    d_mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer with a behavioural d-cache responder.
module tb_dmem_store_buffer;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_byte_enable = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_resp;
    logic        d_mem_read;
    logic        d_mem_write;
    logic [31:0] d_mem_addr;
    logic [31:0] d_mem_wdata;
    logic [3:0]  d_mem_byte_enable;
    logic [31:0] d_mem_rdata = '0;
    logic        d_mem_resp = 1'b0;
    logic        sb_empty;

    int          n_compared = 0;
    int          n_mismatched = 0;
    int          lat = 2;
    bit          hold = 1'b0;
    bit          resp_at_accept = 1'b0;
    int          n_dreads = 0;

    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] cache_mem [logic [29:0]];
    wr_t         wq [$];
    logic [31:0] rq [$];
    logic [32:0] req_log [$];

    dmem_store_buffer dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_read          (cpu_read),
        .cpu_write         (cpu_write),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_byte_enable   (cpu_byte_enable),
        .cpu_rdata         (cpu_rdata),
        .cpu_resp          (cpu_resp),
        .d_mem_read        (d_mem_read),
        .d_mem_write       (d_mem_write),
        .d_mem_addr        (d_mem_addr),
        .d_mem_wdata       (d_mem_wdata),
        .d_mem_byte_enable (d_mem_byte_enable),
        .d_mem_rdata       (d_mem_rdata),
        .d_mem_resp        (d_mem_resp),
        .sb_empty          (sb_empty)
    );

    always #5 clk = ~clk;

    // The CPU side of this bench never issues a load and a store together.
    always @(negedge clk) begin
        assert (!(cpu_read && cpu_write)) else $error("[TB] illegal simultaneous cpu_read and cpu_write");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return {wa, 2'b00} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] read_ref(input logic [29:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] read_cache(input logic [29:0] wa);
        return cache_mem.exists(wa) ? cache_mem[wa] : init_word(wa);
    endfunction

    // Behavioural cache: answers each request after lat cycles, checks writes against the scoreboard.
    initial begin
        int          wait_cnt;
        logic [31:0] snap_addr;
        logic [31:0] snap_data;
        wr_t         w;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                d_mem_resp = 1'b0;
                wait_cnt   = 0;
            end else if (d_mem_resp) begin
                d_mem_resp = 1'b0;
            end else if ((d_mem_read || d_mem_write) && !hold) begin
                if (wait_cnt == 0) begin
                    snap_addr = d_mem_addr;
                    snap_data = d_mem_wdata;
                    req_log.push_back({d_mem_write, d_mem_addr});
                    if (d_mem_read) n_dreads++;
                end else begin
                    checkOutput("dmem_addr_stable", d_mem_addr, snap_addr);
                    checkOutput("dmem_wdata_stable", d_mem_wdata, snap_data);
                end
                wait_cnt++;
                if (wait_cnt >= lat) begin
                    wait_cnt   = 0;
                    d_mem_resp = 1'b1;
                    if (d_mem_write) begin
                        if (wq.size() == 0) begin
                            checkOutput("wr_unexpected", d_mem_addr, 32'hFFFF_FFFF);
                        end else begin
                            w = wq.pop_front();
                            checkOutput("wr_addr", d_mem_addr, w.addr);
                            checkOutput("wr_data", d_mem_wdata, w.data);
                            checkOutput("wr_be", {28'b0, d_mem_byte_enable}, {28'b0, w.be});
                        end
                        cache_mem[d_mem_addr[31:2]] = merge(read_cache(d_mem_addr[31:2]), d_mem_wdata,
                                                            d_mem_byte_enable);
                    end else begin
                        d_mem_rdata = read_cache(d_mem_addr[31:2]);
                    end
                end
            end
        end
    end

    // Drive one CPU access, hold it until cpu_resp, and score load data against the reference.
    task automatic applyStimulus(input bit is_write, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] be, output int cycles);
        wr_t         w;
        logic [31:0] exp_data;
        @(negedge clk);
        if (is_write) begin
            w.addr = {addr[31:2], 2'b00};
            w.data = data;
            w.be   = be;
            wq.push_back(w);
            ref_mem[addr[31:2]] = merge(read_ref(addr[31:2]), data, be);
        end else begin
            rq.push_back(read_ref(addr[31:2]));
        end
        cpu_addr        = addr;
        cpu_wdata       = data;
        cpu_byte_enable = be;
        cpu_write       = is_write;
        cpu_read        = !is_write;
        cycles          = 0;
        #1;
        while (!cpu_resp && cycles < 500) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        resp_at_accept = d_mem_resp;
        if (!cpu_resp) begin
            checkOutput("op_timeout", {31'b0, cpu_resp}, 32'd1);
        end else if (!is_write) begin
            exp_data = rq.pop_front();
            checkOutput("load_data", cpu_rdata, exp_data);
        end
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int k;
        k = 0;
        while (!sb_empty && k < 300) begin
            @(negedge clk);
            k++;
        end
        checkOutput(tag, {31'b0, sb_empty}, 32'd1);
        checkOutput({tag, "_wq"}, wq.size(), 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          cyc;
        int          cyc5;
        int          dr0;
        int          nlog;
        int          k;
        logic [31:0] a;
        logic [3:0]  b;

        repeat (3) @(negedge clk);
        checkOutput("rst_d_mem_read", {31'b0, d_mem_read}, 32'd0);
        checkOutput("rst_d_mem_write", {31'b0, d_mem_write}, 32'd0);
        checkOutput("rst_cpu_resp", {31'b0, cpu_resp}, 32'd0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);
        checkOutput("rst_sb_empty", {31'b0, sb_empty}, 32'd1);
        rst = 1'b0;

        $display("[TB] store then drain");
        lat = 2;
        applyStimulus(1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF, cyc);
        checkOutput("t1_store_latency", cyc, 32'd0);
        wait_empty("t1_empty");

        $display("[TB] full-word forward");
        lat = 3;
        dr0 = n_dreads;
        applyStimulus(1'b1, 32'h2000, 32'h1122_3344, 4'hF, cyc);
        applyStimulus(1'b0, 32'h2000, 32'h0, 4'h0, cyc);
        checkOutput("t2_fwd_latency", cyc, 32'd0);
        wait_empty("t2_empty");
        checkOutput("t2_no_dread", n_dreads, dr0);

        $display("[TB] load bypass and partial conflict");
        lat = 2;
        req_log.delete();
        applyStimulus(1'b1, 32'h3000, 32'hCAFE_F00D, 4'b0011, cyc);
        applyStimulus(1'b0, 32'h3004, 32'h0, 4'h0, cyc);
        applyStimulus(1'b0, 32'h3000, 32'h0, 4'h0, cyc);
        wait_empty("t3_empty");
        checkOutput("t3_req_count", req_log.size(), 32'd3);
        if (req_log.size() >= 3) begin
            checkOutput("t3_req0_is_write", {31'b0, req_log[0][32]}, 32'd0);
            checkOutput("t3_req0_addr", req_log[0][31:0], 32'h3004);
            checkOutput("t3_req1_is_write", {31'b0, req_log[1][32]}, 32'd1);
            checkOutput("t3_req1_addr", req_log[1][31:0], 32'h3000);
            checkOutput("t3_req2_is_write", {31'b0, req_log[2][32]}, 32'd0);
            checkOutput("t3_req2_addr", req_log[2][31:0], 32'h3000);
        end

        $display("[TB] fill to capacity and wrap");
        lat  = 1;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h7000 + 32'(i) * 4, 32'hA000_0000 + 32'(i), 4'hF, cyc);
            checkOutput("t4_fill_latency", cyc, 32'd0);
        end
        fork
            applyStimulus(1'b1, 32'h7010, 32'hA000_0004, 4'hF, cyc5);
            begin
                repeat (6) @(negedge clk);
                hold = 1'b0;
            end
        join
        checkOutput("t4_fifth_stalled", {31'b0, (cyc5 > 0)}, 32'd1);
        checkOutput("t4_accept_on_pop", {31'b0, resp_at_accept}, 32'd1);
        wait_empty("t4_empty");

        $display("[TB] youngest match wins");
        lat = 3;
        applyStimulus(1'b1, 32'h4000, 32'hAAAA_AAAA, 4'hF, cyc);
        applyStimulus(1'b1, 32'h4000, 32'hBBBB_BBBB, 4'hF, cyc);
        applyStimulus(1'b0, 32'h4000, 32'h0, 4'h0, cyc);
        checkOutput("t5_fwd_latency", cyc, 32'd0);
        wait_empty("t5_empty");

        $display("[TB] reset during drain");
        hold = 1'b1;
        applyStimulus(1'b1, 32'h6000, 32'h0101_0101, 4'hF, cyc);
        applyStimulus(1'b1, 32'h6004, 32'h0202_0202, 4'hF, cyc);
        k = 0;
        while (!d_mem_write && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("t6_drain_started", {31'b0, d_mem_write}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_write_dropped", {31'b0, d_mem_write}, 32'd0);
        checkOutput("t6_sb_empty", {31'b0, sb_empty}, 32'd1);
        rst = 1'b0;
        wq.delete();
        hold = 1'b0;
        nlog = req_log.size();
        repeat (20) @(negedge clk);
        checkOutput("t6_no_later_writes", req_log.size(), nlog);

        $display("[TB] mixed random traffic");
        for (int i = 0; i < 30; i++) begin
            a = 32'h5000 + 32'($urandom_range(0, 2)) * 4;
            case ($urandom_range(0, 3))
                0:       b = 4'hF;
                1:       b = 4'b0011;
                2:       b = 4'b1100;
                default: b = 4'b0001;
            endcase
            lat = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) applyStimulus(1'b1, a, $urandom, b, cyc);
            else                           applyStimulus(1'b0, a, 32'h0, 4'h0, cyc);
        end
        wait_empty("rand_empty");
        checkOutput("rq_drained", rq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
